// File: rtl/snn_pkg.sv
// snn_pkg: shared types, default widths and saturating add for the LIF neuron core
package snn_pkg;
    localparam int W_WIDTH = 8;
    localparam int V_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLD} lif_state_t;

    // Sum is exact in 32 bits, then clamped to the signed vw-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b,
                                                   input int unsigned vw);
        logic signed [31:0] s, hi, lo;
        s  = a + b;
        hi = (32'sd1 <<< (vw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (vw - 1));
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction
endpackage

// File: rtl/lif_neuron_core_if.sv
// lif_neuron_core_if: control, weight-write and result bundle of the LIF neuron core
// master drives start/spike_in/weight_wr_*; slave (the core) drives busy/done/spike_out/v_mem/outmem_enable
interface lif_neuron_core_if #(
    parameter int N_IN    = 16,
    parameter int W_WIDTH = 8,
    parameter int V_WIDTH = 16
);
    localparam int AW = $clog2(N_IN);
    logic                      start;
    logic [N_IN-1:0]           spike_in;
    logic                      weight_wr_en;
    logic [AW-1:0]             weight_wr_addr;
    logic [W_WIDTH-1:0]        weight_wr_data;
    logic                      busy;
    logic                      done;
    logic                      spike_out;
    logic signed [V_WIDTH-1:0] v_mem;
    logic                      outmem_enable;

    modport master (output start, spike_in, weight_wr_en, weight_wr_addr, weight_wr_data,
                    input  busy, done, spike_out, v_mem, outmem_enable);
    modport slave  (input  start, spike_in, weight_wr_en, weight_wr_addr, weight_wr_data,
                    output busy, done, spike_out, v_mem, outmem_enable);
endinterface

// File: rtl/synapse_weight_regfile.sv
// synapse_weight_regfile: N_IN signed weights, one write port, one combinational read port
// ports: clk, rst, i_wr_en/i_wr_addr/i_wr_data (write), i_rd_addr -> o_rd_data (read)
module synapse_weight_regfile #(
    parameter int N_IN    = 16,
    parameter int W_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(N_IN)-1:0]  i_wr_addr,
    input  logic [W_WIDTH-1:0]       i_wr_data,
    input  logic [$clog2(N_IN)-1:0]  i_rd_addr,
    output logic [W_WIDTH-1:0]       o_rd_data
);
    logic [W_WIDTH-1:0] r_w [N_IN];

    // A read of the address being written returns the old value; the new one lands at the edge.
    assign o_rd_data = r_w[i_rd_addr];

    always_ff @(posedge clk) begin
        if (rst)
            r_w <= '{default: '0};
        else if (i_wr_en)
            r_w[i_wr_addr] <= i_wr_data;
    end
endmodule

// File: rtl/lif_neuron_core.sv
// lif_neuron_core: time-multiplexed leaky-integrate-and-fire neuron feeding the output spike memory
// ports: clk, rst (sync, active-high), bus (lif_neuron_core_if.slave: start/spike/weight writes in, status/results out)
module lif_neuron_core import snn_pkg::*; #(
    parameter int N_IN       = 16,
    parameter int W_WIDTH    = snn_pkg::W_WIDTH,
    parameter int V_WIDTH    = snn_pkg::V_WIDTH,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 4,
    parameter int V_RESET    = 0,
    parameter int FIRE_HOLD  = 2
) (
    input logic              clk,
    input logic              rst,
    lif_neuron_core_if.slave bus
);
    localparam int AW = $clog2(N_IN);
    localparam int HW = $clog2(FIRE_HOLD);

    lif_state_t                r_state;
    logic [N_IN-1:0]           r_spike;
    logic [AW-1:0]             r_idx;
    logic signed [V_WIDTH-1:0] r_v_work, r_v_mem, w_leak, w_acc;
    logic signed [W_WIDTH-1:0] w_weight;
    logic signed [31:0]        w_sum;
    logic [HW-1:0]             r_hold;
    logic                      r_busy, r_done, r_spike_out, r_outmem;

    synapse_weight_regfile #(.N_IN(N_IN), .W_WIDTH(W_WIDTH)) u_weights (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.weight_wr_en),
        .i_wr_addr (bus.weight_wr_addr),
        .i_wr_data (bus.weight_wr_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_weight)
    );

    assign w_leak = r_v_mem - (r_v_mem >>> LEAK_SHIFT);
    assign w_sum  = sat_add(32'(r_v_work), 32'(w_weight), V_WIDTH);
    assign w_acc  = r_spike[r_idx] ? w_sum[V_WIDTH-1:0] : r_v_work;

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.spike_out     = r_spike_out;
    assign bus.v_mem         = r_v_mem;
    assign bus.outmem_enable = r_outmem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_spike     <= '0;
            r_idx       <= '0;
            r_v_work    <= '0;
            r_v_mem     <= V_WIDTH'(V_RESET);
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spike_out <= 1'b0;
            r_outmem    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // The enable countdown outlives HOLD by one cycle, so it runs independently of the state.
            if (r_hold != '0)
                r_hold <= r_hold - 1'b1;
            else
                r_outmem <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_spike     <= bus.spike_in;
                    r_idx       <= '0;
                    r_v_work    <= w_leak;
                    r_spike_out <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= ACCUM;
                end
                ACCUM: begin
                    r_v_work <= w_acc;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == AW'(N_IN - 1))
                        r_state <= FIRE;
                end
                FIRE: begin
                    r_done <= 1'b1;
                    if (r_v_work >= THRESH) begin
                        r_v_mem     <= V_WIDTH'(V_RESET);
                        r_spike_out <= 1'b1;
                        r_outmem    <= 1'b1;
                        r_hold      <= HW'(FIRE_HOLD - 1);
                        r_state     <= HOLD;
                    end else begin
                        r_v_mem <= r_v_work;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                HOLD: if (r_hold == HW'(1)) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_neuron_core.sv
// tb_lif_neuron_core: scoreboard bench for lif_neuron_core (default widths plus a 10-bit saturation instance)
module tb_lif_neuron_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {int v; bit so;} exp_t;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    lif_neuron_core_if #(.N_IN(16), .W_WIDTH(8), .V_WIDTH(16)) ifa ();
    lif_neuron_core_if #(.N_IN(16), .W_WIDTH(8), .V_WIDTH(10)) ifb ();

    lif_neuron_core #(.N_IN(16), .W_WIDTH(8), .V_WIDTH(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    lif_neuron_core #(.N_IN(16), .W_WIDTH(8), .V_WIDTH(10)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ifa.done) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_v_mem", int'(ifa.v_mem), e.v);
                chk("a_spike_out", int'(ifa.spike_out), int'(e.so));
            end
        end
        if (ifb.done) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_v_mem", int'(ifb.v_mem), e.v);
                chk("b_spike_out", int'(ifb.spike_out), int'(e.so));
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, int'(ifa.busy), 0);
        chk({nm, "_done"}, int'(ifa.done), 0);
        chk({nm, "_spike_out"}, int'(ifa.spike_out), 0);
        chk({nm, "_outmem"}, int'(ifa.outmem_enable), 0);
        chk({nm, "_v_mem"}, int'(ifa.v_mem), 0);
    endtask

    // One timestep on DUT A, start sampled at E0; loop index k means the edge Ek has just passed.
    task automatic run_ts(input logic [15:0] sp, input int wr_e, input logic [3:0] wa, input logic [7:0] wd,
                          input int st_e, input int rs_e, input int e_done, input int e_oe, input int e_bl,
                          input int e_nd, input string nm);
        int d_edge = -1;
        int oe = 0;
        int bl = -1;
        int nd = 0;
        ifa.start = 1'b1;
        ifa.spike_in = sp;
        cyc(1);
        ifa.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            ifa.weight_wr_en = (k == wr_e);
            ifa.weight_wr_addr = wa;
            ifa.weight_wr_data = wd;
            ifa.start = (k == st_e);
            rst = (k == rs_e);
            cyc(1);
            if (ifa.done) begin
                nd++;
                if (d_edge < 0) d_edge = k;
            end
            if (ifa.outmem_enable) oe++;
            if (!ifa.busy && bl < 0) bl = k;
            if (k == rs_e) chk_zero({nm, "_after_rst"});
        end
        ifa.weight_wr_en = 1'b0;
        ifa.start = 1'b0;
        rst = 1'b0;
        chk({nm, "_done_edge"}, d_edge, e_done);
        chk({nm, "_outmem_cycles"}, oe, e_oe);
        chk({nm, "_busy_low_edge"}, bl, e_bl);
        chk({nm, "_done_count"}, nd, e_nd);
    endtask

    task automatic seq_a();
        rst = 1'b1;
        cyc(2);
        chk_zero("reset");
        rst = 1'b0;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            ifa.weight_wr_en = 1'b1;
            ifa.weight_wr_addr = 4'(i);
            ifa.weight_wr_data = 8'd10;
            cyc(1);
        end
        ifa.weight_wr_en = 1'b0;
        qa.push_back('{60, 1'b0});
        run_ts(16'h003F, -1, 4'd0, 8'd0, -1, -1, 17, 0, 17, 1, "subthr");
        qa.push_back('{0, 1'b1});
        run_ts(16'h0001, -1, 4'd0, 8'd0, -1, -1, 17, 2, 18, 1, "fire");
        qa.push_back('{50, 1'b0});
        run_ts(16'h0400, 3, 4'd10, 8'd50, 5, -1, 17, 0, 17, 1, "wr_early");
        qa.push_back('{0, 1'b1});
        run_ts(16'h0400, 12, 4'd10, 8'hEC, -1, -1, 17, 2, 18, 1, "wr_late");
        qa.push_back('{20, 1'b0});
        run_ts(16'h0003, -1, 4'd0, 8'd0, -1, -1, 17, 0, 17, 1, "two_spk");
        run_ts(16'hFFFF, -1, 4'd0, 8'd0, -1, 8, -1, 0, 8, 0, "rst_mid");
        qa.push_back('{0, 1'b0});
        run_ts(16'hFFFF, -1, 4'd0, 8'd0, -1, -1, 17, 0, 17, 1, "post_rst");
    endtask

    task automatic wait_done_b(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            cyc(1);
            if (ifb.done) got = 1'b1;
        end
        chk(nm, int'(got), 1);
    endtask

    task automatic seq_b();
        rst_b = 1'b1;
        cyc(2);
        rst_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ifb.weight_wr_en = 1'b1;
            ifb.weight_wr_addr = 4'(i);
            ifb.weight_wr_data = 8'h80;
            cyc(1);
        end
        ifb.weight_wr_en = 1'b0;
        qb.push_back('{-512, 1'b0});
        ifb.start = 1'b1;
        ifb.spike_in = 16'hFFFF;
        cyc(1);
        ifb.start = 1'b0;
        wait_done_b("b_sat_done_seen");
        cyc(2);
        qb.push_back('{-480, 1'b0});
        ifb.start = 1'b1;
        ifb.spike_in = 16'h0000;
        cyc(1);
        ifb.start = 1'b0;
        wait_done_b("b_leak_done_seen");
    endtask

    initial begin
        ifa.start = 1'b0;
        ifa.spike_in = '0;
        ifa.weight_wr_en = 1'b0;
        ifa.weight_wr_addr = '0;
        ifa.weight_wr_data = '0;
        ifb.start = 1'b0;
        ifb.spike_in = '0;
        ifb.weight_wr_en = 1'b0;
        ifb.weight_wr_addr = '0;
        ifb.weight_wr_data = '0;
        fork
            seq_a();
            seq_b();
        join
        cyc(3);
        chk("a_pending_expectations", qa.size(), 0);
        chk("b_pending_expectations", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
